// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg : shared IDs, size encodings and request field widths
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int SIZE_W  = 2;
  localparam int WSTRB_W = 4;

endpackage

`default_nettype wire

// File: rtl/arb_id_fifo.sv
// ============================================================================
// arb_id_fifo : in-order 1-bit master-ID FIFO for outstanding transactions
// Revision    : 1.0
// ============================================================================
`default_nettype none

module arb_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   din,
  output logic                   dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(DEPTH);

  logic             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_cnt == c_cnt_full);
  assign empty     = (r_cnt == '0);
  assign cnt       = r_cnt;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + CNT_W'(1);
      else if (w_do_pop && !w_do_push) r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : inst/data two-master to one-slave SRAM-like memory arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic               clk,
  input  logic               resetn,

  input  logic               inst_req,
  input  logic               inst_wr,
  input  logic [SIZE_W-1:0]  inst_size,
  input  logic [WSTRB_W-1:0] inst_wstrb,
  input  logic [ADDR_W-1:0]  inst_addr,
  input  logic [DATA_W-1:0]  inst_wdata,
  output logic               inst_addr_ok,
  output logic               inst_data_ok,
  output logic [DATA_W-1:0]  inst_rdata,

  input  logic               data_req,
  input  logic               data_wr,
  input  logic [SIZE_W-1:0]  data_size,
  input  logic [WSTRB_W-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]  data_addr,
  input  logic [DATA_W-1:0]  data_wdata,
  output logic               data_addr_ok,
  output logic               data_data_ok,
  output logic [DATA_W-1:0]  data_rdata,

  output logic               mem_req,
  output logic               mem_wr,
  output logic [SIZE_W-1:0]  mem_size,
  output logic [WSTRB_W-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_addr_ok,
  input  logic               mem_data_ok,
  input  logic [DATA_W-1:0]  mem_rdata
);

  localparam int CNT_W = $clog2(MAX_OUTST) + 1;
  localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(MAX_OUTST);

  logic             r_lock;
  logic             r_lock_id;
  logic             r_prefer;

  logic             w_grant;
  logic             w_grant_vld;
  logic             w_both;
  logic             w_sel_req;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_head_id;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_cnt;

  assign w_both = inst_req & data_req;

  always_comb begin
    w_grant     = ID_INST;
    w_grant_vld = 1'b0;
    if (r_lock) begin
      w_grant     = r_lock_id;
      w_grant_vld = 1'b1;
    end else if (w_both) begin
      w_grant     = r_prefer;
      w_grant_vld = 1'b1;
    end else if (inst_req) begin
      w_grant     = ID_INST;
      w_grant_vld = 1'b1;
    end else if (data_req) begin
      w_grant     = ID_DATA;
      w_grant_vld = 1'b1;
    end
  end

  assign w_sel_req = (w_grant == ID_DATA) ? data_req : inst_req;
  // Registered count gates the request, so a same-cycle pop cannot free a slot.
  assign mem_req   = w_grant_vld & w_sel_req & (w_cnt != c_cnt_full);

  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = '0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_grant_vld) begin
      if (w_grant == ID_DATA) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_wstrb = inst_wstrb;
        mem_addr  = inst_addr;
        mem_wdata = inst_wdata;
      end
    end
  end

  assign w_accept     = mem_req & mem_addr_ok;
  assign inst_addr_ok = w_accept & (w_grant == ID_INST);
  assign data_addr_ok = w_accept & (w_grant == ID_DATA);

  assign w_push       = w_accept & ~w_fifo_full;
  assign w_pop        = mem_data_ok & ~w_fifo_empty;
  assign inst_data_ok = w_pop & (w_head_id == ID_INST);
  assign data_data_ok = w_pop & (w_head_id == ID_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  arb_id_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (w_push),
    .pop    (w_pop),
    .din    (w_grant),
    .dout   (w_head_id),
    .full   (w_fifo_full),
    .empty  (w_fifo_empty),
    .cnt    (w_cnt)
  );

  // Lock keeps a presented-but-unaccepted request on the same master.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lock    <= 1'b0;
      r_lock_id <= ID_INST;
      r_prefer  <= ID_DATA;
    end else begin
      if (w_accept) begin
        r_lock <= 1'b0;
        if (w_both) r_prefer <= ~w_grant;
      end else if (mem_req) begin
        r_lock    <= 1'b1;
        r_lock_id <= w_grant;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : scoreboard bench for mem_arbiter (in-order response routing)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct {
    logic        id;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = SZ_WORD; inst_wstrb = 4'hF;
    inst_addr = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = SZ_WORD; data_wstrb = 4'hF;
    data_addr = '0; data_wdata = '0;
    mem_addr_ok = 0; mem_data_ok = 0;
  endtask

  // Advance to the drive point of the next cycle; checks follow #4 later.
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Drains every scoreboard entry with back-to-back responses.
  task automatic test_drain(input string tag);
    exp_t e;
    while (sb.size() > 0) begin
      next_cycle();
      idle_inputs();
      e = sb.pop_front();
      mem_data_ok = 1; mem_rdata = e.rdata;
      #4;
      checks++;
      if (inst_data_ok !== (e.id == ID_INST) || data_data_ok !== (e.id == ID_DATA) ||
          inst_rdata !== e.rdata || data_rdata !== e.rdata)
      begin
        errors++;
        $display("FAIL %s_resp: inst_ok=%b data_ok=%b rdata=%h, required id=%b rdata=%h",
                 tag, inst_data_ok, data_data_ok, inst_rdata, e.id, e.rdata);
      end
    end
    next_cycle();
    idle_inputs();
    #4;
    checks++;
    if (dut.w_cnt !== 3'd0) begin
      errors++; $display("FAIL %s_cnt_empty: cnt=%0d, required 0", tag, dut.w_cnt);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 0; mem_rdata = 32'h5A5A_5A5A;
    #2;
    repeat (2) begin
      next_cycle();
      #4;
      checks++;
      if ({mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} !== '0) begin
        errors++; $display("FAIL reset_mem: req=%b addr=%h, required all zero", mem_req, mem_addr);
      end
      checks++;
      if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0) begin
        errors++; $display("FAIL reset_oks: %b%b%b%b, required 0000",
                           inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok);
      end
      checks++;
      if (inst_rdata !== 32'h5A5A_5A5A || data_rdata !== 32'h5A5A_5A5A) begin
        errors++; $display("FAIL reset_rdata: %h/%h, required 5a5a5a5a", inst_rdata, data_rdata);
      end
      checks++;
      if (dut.w_cnt !== 3'd0 || dut.r_lock !== 1'b0 || dut.r_prefer !== 1'b1) begin
        errors++; $display("FAIL reset_state: cnt=%0d lock=%b prefer=%b, required 0/0/1",
                           dut.w_cnt, dut.r_lock, dut.r_prefer);
      end
    end
    next_cycle();
    resetn = 1;
  endtask

  task automatic test_single_read();
    next_cycle();
    idle_inputs();
    inst_req = 1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1;
    #4;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h1C00_0000 || mem_size !== SZ_WORD ||
        inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin
      errors++; $display("FAIL single_accept: req=%b addr=%h iok=%b dok=%b, required 1/1c000000/1/0",
                         mem_req, mem_addr, inst_addr_ok, data_addr_ok);
    end
    sb.push_back('{id: ID_INST, rdata: 32'hDEAD_BEEF});
    repeat (1) begin
      next_cycle();
      idle_inputs();
      #4;
      checks++;
      if (inst_addr_ok !== 1'b0 || inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
        errors++; $display("FAIL single_gap: iok=%b idok=%b ddok=%b, required 0/0/0",
                           inst_addr_ok, inst_data_ok, data_data_ok);
      end
    end
    test_drain("single");
  endtask

  task automatic test_contention();
    logic exp_id;
    next_cycle();
    idle_inputs();
    resetn = 0;
    next_cycle();
    resetn = 1;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      inst_req = 1; inst_addr = 32'h0000_1100;
      data_req = 1; data_addr = 32'h0000_2200;
      mem_addr_ok = (c == 3);
      #4;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0000_2200 || inst_addr_ok !== 1'b0 ||
          data_addr_ok !== (c == 3)) begin
        errors++; $display("FAIL contention_hold%0d: req=%b addr=%h iok=%b dok=%b, required data held",
                           c, mem_req, mem_addr, inst_addr_ok, data_addr_ok);
      end
      if (c > 0) begin
        checks++;
        if (dut.r_lock !== 1'b1 || dut.r_lock_id !== ID_DATA) begin
          errors++; $display("FAIL contention_lock%0d: lock=%b id=%b, required 1/1",
                             c, dut.r_lock, dut.r_lock_id);
        end
      end
    end
    sb.push_back('{id: ID_DATA, rdata: 32'hC0DE_0000});
    exp_id = ID_INST;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      #4;
      checks++;
      if (mem_addr !== (exp_id == ID_DATA ? 32'h0000_2200 : 32'h0000_1100) ||
          inst_addr_ok !== (exp_id == ID_INST) || data_addr_ok !== (exp_id == ID_DATA)) begin
        errors++; $display("FAIL contention_alt%0d: addr=%h iok=%b dok=%b, required grant %b",
                           c, mem_addr, inst_addr_ok, data_addr_ok, exp_id);
      end
      sb.push_back('{id: exp_id, rdata: 32'hC0DE_0001 + c});
      exp_id = ~exp_id;
    end
    next_cycle();
    #4;
    checks++;
    if (mem_req !== 1'b0 || inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0) begin
      errors++; $display("FAIL contention_full: req=%b, required 0", mem_req);
    end
    test_drain("contention");
  endtask

  task automatic test_full_fifo();
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      idle_inputs();
      inst_req = 1; inst_addr = 32'h0000_3000 + 32'(c * 4); mem_addr_ok = 1;
      #4;
      checks++;
      if (inst_addr_ok !== 1'b1) begin
        errors++; $display("FAIL full_fill%0d: iok=%b, required 1", c, inst_addr_ok);
      end
      sb.push_back('{id: ID_INST, rdata: 32'hF000_0000 + c});
    end
    next_cycle();
    #4;
    checks++;
    if (mem_req !== 1'b0 || inst_addr_ok !== 1'b0 || dut.w_cnt !== 3'd4) begin
      errors++; $display("FAIL full_block: req=%b iok=%b cnt=%0d, required 0/0/4",
                         mem_req, inst_addr_ok, dut.w_cnt);
    end
    next_cycle();
    e = sb.pop_front();
    mem_data_ok = 1; mem_rdata = e.rdata;
    #4;
    checks++;
    if (mem_req !== 1'b0 || dut.r_lock !== 1'b0 || inst_data_ok !== 1'b1 ||
        inst_rdata !== e.rdata) begin
      errors++; $display("FAIL full_pop: req=%b lock=%b idok=%b rdata=%h, required 0/0/1/%h",
                         mem_req, dut.r_lock, inst_data_ok, inst_rdata, e.rdata);
    end
    next_cycle();
    mem_data_ok = 0;
    #4;
    checks++;
    if (mem_req !== 1'b1 || inst_addr_ok !== 1'b1) begin
      errors++; $display("FAIL full_reassert: req=%b iok=%b, required 1/1", mem_req, inst_addr_ok);
    end
    sb.push_back('{id: ID_INST, rdata: 32'hF000_0004});
    test_drain("full");
  endtask

  task automatic test_interleaved();
    exp_t e;
    next_cycle();
    idle_inputs();
    inst_req = 1; inst_addr = 32'h0000_4000; mem_addr_ok = 1;
    #4;
    checks++;
    if (inst_addr_ok !== 1'b1) begin
      errors++; $display("FAIL inter_a: iok=%b, required 1", inst_addr_ok);
    end
    sb.push_back('{id: ID_INST, rdata: 32'h1});
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      idle_inputs();
      data_req = 1; data_addr = 32'h0000_5000 + 32'(c * 4); data_wr = 1; mem_addr_ok = 1;
      sb.push_back('{id: ID_DATA, rdata: 32'h2 + c});
      if (c == 1) begin
        e = sb.pop_front();
        mem_data_ok = 1; mem_rdata = e.rdata;
      end
      #4;
      checks++;
      if (data_addr_ok !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 32'h0000_5000 + 32'(c * 4)) begin
        errors++; $display("FAIL inter_data%0d: dok=%b wr=%b addr=%h, required 1/1", c,
                           data_addr_ok, mem_wr, mem_addr);
      end
      if (c == 1) begin
        checks++;
        if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== e.rdata ||
            dut.w_cnt !== 3'd2) begin
          errors++; $display("FAIL inter_pushpop: idok=%b ddok=%b rdata=%h cnt=%0d, required 1/0/%h/2",
                             inst_data_ok, data_data_ok, inst_rdata, dut.w_cnt, e.rdata);
        end
      end
    end
    next_cycle();
    idle_inputs();
    inst_req = 1; inst_addr = 32'h0000_4004; mem_addr_ok = 1;
    #4;
    checks++;
    if (inst_addr_ok !== 1'b1 || dut.w_cnt !== 3'd2) begin
      errors++; $display("FAIL inter_d: iok=%b cnt=%0d, required 1/2", inst_addr_ok, dut.w_cnt);
    end
    sb.push_back('{id: ID_INST, rdata: 32'h4});
    test_drain("inter");
  endtask

  task automatic test_spurious_reset();
    next_cycle();
    idle_inputs();
    mem_data_ok = 1; mem_rdata = 32'h0BAD_0BAD;
    #4;
    checks++;
    if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
      errors++; $display("FAIL spurious_ok: idok=%b ddok=%b, required 0/0", inst_data_ok, data_data_ok);
    end
    next_cycle();
    idle_inputs();
    #4;
    checks++;
    if (dut.w_cnt !== 3'd0) begin
      errors++; $display("FAIL spurious_cnt: cnt=%0d, required 0", dut.w_cnt);
    end
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      idle_inputs();
      inst_req = 1; inst_addr = 32'h0000_6000 + 32'(c * 4); mem_addr_ok = 1;
    end
    next_cycle();
    idle_inputs();
    data_req = 1; data_addr = 32'h0000_7000;
    next_cycle();
    #4;
    checks++;
    if (dut.w_cnt !== 3'd3 || dut.r_lock !== 1'b1) begin
      errors++; $display("FAIL prereset_state: cnt=%0d lock=%b, required 3/1", dut.w_cnt, dut.r_lock);
    end
    idle_inputs();
    resetn = 0;
    #1;
    checks++;
    if (dut.w_cnt !== 3'd0 || dut.r_lock !== 1'b0 || dut.r_prefer !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL midreset: cnt=%0d lock=%b prefer=%b req=%b, required 0/0/1/0",
                         dut.w_cnt, dut.r_lock, dut.r_prefer, mem_req);
    end
    next_cycle();
    #4;
    checks++;
    if (mem_req !== 1'b0 || dut.w_cnt !== 3'd0) begin
      errors++; $display("FAIL reset_held: req=%b cnt=%0d, required 0/0", mem_req, dut.w_cnt);
    end
    sb.delete();
    next_cycle();
    resetn = 1;
  endtask

  initial begin
    resetn = 0;
    idle_inputs();
    mem_rdata = '0;
    test_reset();
    test_single_read();
    test_contention();
    test_full_fifo();
    test_interleaved();
    test_spurious_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
